// File: rtl/mips_pkg.sv
// Shared MIPS pipeline constants: NOP encoding, default widths and the IF/ID
// pipeline-register field layout used by the fetch stage.
package mips_pkg;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0020;
  localparam int          IMEM_ADDR_W = 7;
  localparam int          PERF_CNT_W  = 16;

  // IF/ID register packing, LSB first: {valid, pc1, instr}
  localparam int IFID_INSTR_LSB = 0;
  localparam int IFID_INSTR_W   = 32;
  localparam int IFID_PC1_LSB   = IFID_INSTR_LSB + IFID_INSTR_W;

  function automatic int ifid_valid_bit(input int addr_w);
    return IFID_PC1_LSB + addr_w;
  endfunction

  function automatic int ifid_width(input int addr_w);
    return IFID_PC1_LSB + addr_w + 1;
  endfunction

endpackage

// File: rtl/if_stage_if.sv
// Fetch-stage bus: hazard/redirect controls in, instruction memory port,
// IF/ID pipeline register and performance counters out.
interface if_stage_if
  import mips_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int CNT_W  = PERF_CNT_W
) ();

  logic              stall;
  logic              redirect;
  logic [ADDR_W-1:0] redirect_pc;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_data;
  logic [31:0]       ifid_instr;
  logic [ADDR_W-1:0] ifid_pc1;
  logic              ifid_valid;
  logic [CNT_W-1:0]  fetch_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  modport master (
    input  stall, redirect, redirect_pc, imem_data,
    output imem_addr, ifid_instr, ifid_pc1, ifid_valid, fetch_cnt, bubble_cnt
  );

  modport slave (
    output stall, redirect, redirect_pc, imem_data,
    input  imem_addr, ifid_instr, ifid_pc1, ifid_valid, fetch_cnt, bubble_cnt
  );

endinterface

// File: rtl/if_stage_sat_counter.sv
// Up-counter that sticks at its all-ones value instead of wrapping.
module sat_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         i_inc,
  output logic [W-1:0] o_count
);

  logic [W-1:0] r_count;
  logic         w_at_max;

  assign w_at_max = (r_count == {W{1'b1}});
  assign o_count  = r_count;

  // count enabled events until the maximum is reached
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_count <= {W{1'b0}};
    end else if (i_inc && !w_at_max) begin
      r_count <= r_count + {{(W-1){1'b0}}, 1'b1};
    end else begin
      r_count <= r_count;
    end
  end

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: owns the PC, captures memory data into IF/ID,
// honours stall and redirect (redirect wins), counts fetches and bubbles.
module if_stage
  import mips_pkg::*;
#(
  parameter int ADDR_W = IMEM_ADDR_W,
  parameter int CNT_W  = PERF_CNT_W
) (
  input logic          clk,
  input logic          reset_n,
  if_stage_if.master   bus
);

  localparam int IFID_W    = ifid_width(ADDR_W);
  localparam int VALID_BIT = ifid_valid_bit(ADDR_W);

  logic [ADDR_W-1:0] r_pc;
  logic [IFID_W-1:0] r_ifid;
  logic [ADDR_W-1:0] w_pc_inc;
  logic [IFID_W-1:0] w_ifid_nop;
  logic [IFID_W-1:0] w_ifid_fetch;
  logic              w_fetch_en;
  logic              w_bubble_en;
  logic [CNT_W-1:0]  w_fetch_cnt;
  logic [CNT_W-1:0]  w_bubble_cnt;

  // PC arithmetic wraps naturally at 2^ADDR_W
  assign w_pc_inc     = r_pc + {{(ADDR_W-1){1'b0}}, 1'b1};
  assign w_ifid_nop   = {1'b0, {ADDR_W{1'b0}}, NOP_INSTR};
  assign w_ifid_fetch = {1'b1, w_pc_inc, bus.imem_data};
  assign w_fetch_en   = !bus.redirect && !bus.stall;
  assign w_bubble_en  = bus.redirect || bus.stall;

  // PC and IF/ID update: redirect squashes, stall holds, otherwise fetch
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pc   <= {ADDR_W{1'b0}};
      r_ifid <= w_ifid_nop;
    end else if (bus.redirect) begin
      r_pc   <= bus.redirect_pc;
      r_ifid <= w_ifid_nop;
    end else if (bus.stall) begin
      r_pc   <= r_pc;
      r_ifid <= r_ifid;
    end else begin
      r_pc   <= w_pc_inc;
      r_ifid <= w_ifid_fetch;
    end
  end

  sat_counter #(.W(CNT_W)) u_fetch_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_fetch_en),
    .o_count (w_fetch_cnt)
  );

  sat_counter #(.W(CNT_W)) u_bubble_cnt (
    .clk     (clk),
    .reset_n (reset_n),
    .i_inc   (w_bubble_en),
    .o_count (w_bubble_cnt)
  );

  assign bus.imem_addr  = r_pc;
  assign bus.ifid_instr = r_ifid[IFID_INSTR_LSB +: IFID_INSTR_W];
  assign bus.ifid_pc1   = r_ifid[IFID_PC1_LSB +: ADDR_W];
  assign bus.ifid_valid = r_ifid[VALID_BIT];
  assign bus.fetch_cnt  = w_fetch_cnt;
  assign bus.bubble_cnt = w_bubble_cnt;

endmodule

// File: tb/tb_if_stage.sv
// Bench for if_stage: directed scenarios plus random stall/redirect traffic,
// checked every cycle against a behavioural fetch model; a CNT_W=4 copy shows saturation.
module tb_if_stage;
  import mips_pkg::*;

  localparam logic [31:0] ADD_S2 = 32'h0233_9020;
  localparam logic [31:0] NOR_S7 = 32'h02B6_B827;

  logic clk = 1'b0;
  logic reset_n = 1'b1;
  always #5 clk = ~clk;

  if_stage_if #(.ADDR_W(7), .CNT_W(16)) bus ();
  if_stage_if #(.ADDR_W(7), .CNT_W(4))  bus4 ();

  if_stage #(.ADDR_W(7), .CNT_W(16)) dut  (.clk(clk), .reset_n(reset_n), .bus(bus));
  if_stage #(.ADDR_W(7), .CNT_W(4))  dut4 (.clk(clk), .reset_n(reset_n), .bus(bus4));

  logic [31:0] mem [0:63];

  // upper half of the address space is unpopulated and reads as NOP
  function automatic logic [31:0] memfn(input logic [6:0] a);
    return a[6] ? NOP_INSTR : mem[a[5:0]];
  endfunction

  assign bus.imem_data    = memfn(bus.imem_addr);
  assign bus4.imem_data   = memfn(bus4.imem_addr);
  assign bus4.stall       = bus.stall;
  assign bus4.redirect    = bus.redirect;
  assign bus4.redirect_pc = bus.redirect_pc;

  int checks = 0;
  int failures = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // behavioural model: architectural fetch state and raw event totals
  int          m_pc;
  logic [31:0] m_instr;
  int          m_pc1;
  bit          m_valid;
  int          m_f;
  int          m_b;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_pc <= 0; m_instr <= NOP_INSTR; m_pc1 <= 0; m_valid <= 1'b0; m_f <= 0; m_b <= 0;
    end else if (bus.redirect) begin
      m_pc <= int'(bus.redirect_pc); m_instr <= NOP_INSTR; m_pc1 <= 0; m_valid <= 1'b0;
      m_b <= m_b + 1;
    end else if (bus.stall) begin
      m_b <= m_b + 1;
    end else begin
      m_instr <= memfn(7'(m_pc));
      m_pc1   <= (m_pc + 1) % 128;
      m_valid <= 1'b1;
      m_pc    <= (m_pc + 1) % 128;
      m_f     <= m_f + 1;
    end
  end

  function automatic int sat(input int v, input int mx);
    return (v > mx) ? mx : v;
  endfunction

  // per-cycle comparison of both DUT copies against the model
  always @(negedge clk) begin
    if (cmp_en) begin
      chk("imem_addr",  64'(bus.imem_addr),  64'(m_pc));
      chk("ifid_instr", 64'(bus.ifid_instr), 64'(m_instr));
      chk("ifid_pc1",   64'(bus.ifid_pc1),   64'(m_pc1));
      chk("ifid_valid", 64'(bus.ifid_valid), 64'(m_valid));
      chk("fetch_cnt",  64'(bus.fetch_cnt),  64'(sat(m_f, 65535)));
      chk("bubble_cnt", 64'(bus.bubble_cnt), 64'(sat(m_b, 65535)));
      chk("w4_instr",   64'(bus4.ifid_instr), 64'(m_instr));
      chk("w4_fetch",   64'(bus4.fetch_cnt),  64'(sat(m_f, 15)));
      chk("w4_bubble",  64'(bus4.bubble_cnt), 64'(sat(m_b, 15)));
    end
  end

  task automatic cyc(input bit s, input bit r, input logic [6:0] p);
    bus.stall = s;
    bus.redirect = r;
    bus.redirect_pc = p;
    @(negedge clk);
  endtask

  initial begin
    int n;
    int b_before;
    for (int i = 0; i < 64; i++) mem[i] = $urandom;
    mem[0] = 32'h2008_0005; mem[1] = 32'h2009_000A; mem[2] = ADD_S2;
    mem[3] = 32'h0233_8822; mem[4] = 32'h0233_A024; mem[13] = NOR_S7;
    bus.stall = 1'b0; bus.redirect = 1'b0; bus.redirect_pc = 7'd0;

    #1 reset_n = 1'b0;
    @(negedge clk);
    chk("rst_instr", 64'(bus.ifid_instr), 64'h20);
    chk("rst_valid", 64'(bus.ifid_valid), 64'h0);
    chk("rst_addr",  64'(bus.imem_addr),  64'h0);
    cmp_en = 1'b1;
    @(negedge clk);
    reset_n = 1'b1;

    // free run: first edge brings mem[0]
    cyc(1'b0, 1'b0, 7'd0);
    chk("first_instr", 64'(bus.ifid_instr), 64'h2008_0005);
    chk("first_pc1",   64'(bus.ifid_pc1),   64'd1);
    chk("first_addr",  64'(bus.imem_addr),  64'd1);
    cyc(1'b0, 1'b0, 7'd0);
    cyc(1'b0, 1'b0, 7'd0);
    chk("run_instr2", 64'(bus.ifid_instr), 64'(ADD_S2));

    // one-cycle stall while holding add s2
    cyc(1'b1, 1'b0, 7'd0);
    chk("stall_hold",  64'(bus.ifid_instr), 64'(ADD_S2));
    chk("stall_addr",  64'(bus.imem_addr),  64'd3);
    chk("stall_bub",   64'(bus.bubble_cnt), 64'd1);
    cyc(1'b0, 1'b0, 7'd0);
    chk("after_stall", 64'(bus.ifid_instr), 64'h0233_8822);
    chk("after_pc1",   64'(bus.ifid_pc1),   64'd4);

    // run up to PC=9, then redirect to 13
    n = 0;
    while (bus.imem_addr != 7'd9 && n < 200) begin
      cyc(1'b0, 1'b0, 7'd0);
      n++;
    end
    chk("reach_pc9", 64'(bus.imem_addr), 64'd9);
    cyc(1'b0, 1'b1, 7'd13);
    chk("redir_nop",   64'(bus.ifid_instr), 64'h20);
    chk("redir_valid", 64'(bus.ifid_valid), 64'd0);
    cyc(1'b0, 1'b0, 7'd0);
    chk("redir_tgt",   64'(bus.ifid_instr), 64'(NOR_S7));
    chk("redir_pc1",   64'(bus.ifid_pc1),   64'd14);

    // redirect beats stall, one bubble only
    b_before = m_b;
    cyc(1'b1, 1'b1, 7'd3);
    chk("rs_addr",  64'(bus.imem_addr),  64'd3);
    chk("rs_valid", 64'(bus.ifid_valid), 64'd0);
    chk("rs_bub",   64'(bus.bubble_cnt), 64'(b_before + 1));

    // PC wrap from 127 to 0
    cyc(1'b0, 1'b1, 7'd126);
    chk("wrap_126", 64'(bus.imem_addr), 64'd126);
    cyc(1'b0, 1'b0, 7'd0);
    chk("wrap_127", 64'(bus.imem_addr), 64'd127);
    cyc(1'b0, 1'b0, 7'd0);
    chk("wrap_0",     64'(bus.imem_addr),  64'd0);
    chk("wrap_instr", 64'(bus.ifid_instr), 64'h20);
    chk("wrap_valid", 64'(bus.ifid_valid), 64'd1);
    chk("wrap_pc1",   64'(bus.ifid_pc1),   64'd0);

    // random traffic
    for (int i = 0; i < 400; i++)
      cyc(($urandom % 4) == 0, ($urandom % 10) == 0, 7'($urandom_range(0, 127)));
    chk("sat4_fetch", 64'(bus4.fetch_cnt), 64'd15);

    // async reset between edges during a redirect
    bus.stall = 1'b0; bus.redirect = 1'b1; bus.redirect_pc = 7'd50;
    @(posedge clk);
    #2 reset_n = 1'b0;
    #1;
    chk("arst_addr",  64'(bus.imem_addr),  64'd0);
    chk("arst_instr", 64'(bus.ifid_instr), 64'h20);
    chk("arst_pc1",   64'(bus.ifid_pc1),   64'd0);
    chk("arst_valid", 64'(bus.ifid_valid), 64'd0);
    chk("arst_fcnt",  64'(bus.fetch_cnt),  64'd0);
    chk("arst_bcnt",  64'(bus.bubble_cnt), 64'd0);
    @(negedge clk);
    bus.redirect = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;
    cyc(1'b0, 1'b0, 7'd0);
    chk("post_rst", 64'(bus.ifid_instr), 64'h2008_0005);
    for (int i = 0; i < 60; i++)
      cyc(($urandom % 5) == 0, ($urandom % 12) == 0, 7'($urandom_range(0, 127)));

    cmp_en = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/if_stage.md
# if_stage

Instruction-fetch stage of the 5-stage MIPS pipeline. Owns the program counter, drives the word address into `Instruction_Mem`, and captures the returned instruction into the IF/ID pipeline register. Honours load-use stalls and branch/jump redirects from the decode stage, squashing the wrong-path fetch. Keeps two saturating performance counters for the verification bench.

## Interface
- `ADDR_W`, default 7: PC width in words; matches the instruction memory index width.
- `CNT_W`, default 16: performance counter width.
- `clk`  in  1  rising-edge clock.
- `reset_n`  in  1  asynchronous, active-low reset.
- `stall`  in  1  hazard unit: hold PC and IF/ID this cycle.
- `redirect`  in  1  decode stage: taken branch or jump resolved.
- `redirect_pc`  in  ADDR_W  word-index target for `redirect`.
- `imem_addr`  out  ADDR_W  word address to instruction memory; combinational copy of PC.
- `imem_data`  in  32  instruction returned by memory; combinational, same cycle.
- `ifid_instr`  out  32  registered instruction to decode.
- `ifid_pc1`  out  ADDR_W  registered PC+1 of that instruction, for branch/jump target math.
- `ifid_valid`  out  1  IF/ID holds a real fetched instruction.
- `fetch_cnt`  out  CNT_W  instructions accepted into IF/ID.
- `bubble_cnt`  out  CNT_W  cycles IF/ID was stalled or squashed.

## Operation
- Reset (async assert, any cycle, including mid-redirect): PC=0, `ifid_instr`=NOP (32'h0000_0020, add $zero,$zero,$zero), `ifid_pc1`=0, `ifid_valid`=0, both counters=0. No fetch state survives reset.
- Per-edge priority, highest first:
  - `redirect`: PC<=`redirect_pc`; IF/ID<=NOP, valid=0, pc1=0; `bubble_cnt`++. Wins over a simultaneous `stall`.
  - `stall`: PC and IF/ID hold all fields; `bubble_cnt`++.
  - Normal: IF/ID<=`imem_data`, `ifid_pc1`<=PC+1, valid=1; PC<=PC+1; `fetch_cnt`++.
- PC arithmetic is modulo 2^ADDR_W: PC=127 advances to 0, `ifid_pc1`=0.
- No PC range check here: addresses with bit ADDR_W-1 set return NOP from memory and are still fetched as valid.
- Counters saturate at 2^CNT_W-1 and never wrap.
- `redirect_pc` is sampled only when `redirect`=1; otherwise it is ignored.

## Timing
- Fetch latency: one cycle. Instruction at PC=n appears on `ifid_instr` the cycle after `imem_addr`=n.
- After `reset_n` deasserts, first edge: `ifid_instr`=mem[0], `ifid_pc1`=1, valid=1, `imem_addr`=1.
- Redirect penalty: one bubble. Target's instruction reaches IF/ID on the second edge after `redirect` is sampled.
- Stall of k cycles: IF/ID and `imem_addr` frozen for k edges; normal advance on the first edge with `stall`=0.
- `imem_addr` is a direct wire from the PC register; there is no combinational path from any input to any output.

## Structure
- Shared package `mips_pkg`: `NOP_INSTR` = 32'h0000_0020, `IMEM_ADDR_W` = 7, `PERF_CNT_W` = 16. Pipeline-register field layout goes in the package as constants, not a local definition.
- One sub-module, `sat_counter` (width parameter, increment enable, saturate), instantiated twice. Everything else lives inline.

## Test plan
- Reset, then free-run 5 cycles with the team program loaded: IF/ID shows mem[0..4] in order, `ifid_pc1`=1..5, `fetch_cnt`=5, `bubble_cnt`=0.
- `stall` high for 1 cycle while IF/ID holds mem[2] (add s2): mem[2] held for 2 cycles, `imem_addr` stays 3, then mem[3] arrives; `bubble_cnt`=1.
- `redirect`=1 with `redirect_pc`=13 while PC=9: next IF/ID is NOP with valid=0, following IF/ID is mem[13] (nor s7) with pc1=14.
- `redirect` and `stall` asserted together, `redirect_pc`=3: redirect wins, PC=3, IF/ID=NOP/valid 0; `bubble_cnt` increments by exactly 1.
- Start PC at 126 via redirect and free-run: `imem_addr` goes 126, 127, 0. IF/ID receives NOP from 127 as valid and `ifid_pc1`=0.
- Assert `reset_n` low asynchronously between edges during a redirect: outputs go to reset values immediately. Preload counters near max (force CNT_W=4 build): 20 fetches leave `fetch_cnt`=15.
